ef_psram_ahbl_rbuf: RTL and testbench

- AHB-Lite slave front end for the quad-SPI/QPI PSRAM serial engine.
- Adds a parametrised direct-mapped read line buffer with zero-wait-state hits, and write-through with byte-lane merge.
- Adds readable configuration/status registers.
- Drives a start/done engine interface with streamed read data; sits between the AHB-Lite fabric and the PSRAM PHY engine.

---
 rtl/ef_psram_ahbl_rbuf.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ef_psram_ahbl_rbuf.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_psram_ahbl_rbuf.sv
`default_nettype none
// ============================================================================
// ef_psram_ahbl_rbuf : AHB-Lite front end for the PSRAM engine, with a direct-mapped read line buffer
// Revision: 1.0
// ============================================================================
module ef_psram_ahbl_rbuf #(
  parameter int ADDR_W     = 24,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4,
  parameter int WS_W       = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic              HWRITE,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic              mem_start,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [6:0]        mem_size,
  output logic [7:0]        mem_cmd,
  output logic [31:0]       mem_wdata,
  output logic [WS_W-1:0]   mem_wait,
  output logic              mem_qspi,
  output logic              mem_qpi,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_done
);

  localparam int c_OFF_W = $clog2(4 * LINE_WORDS);
  localparam int c_WO_W  = $clog2(LINE_WORDS);
  localparam int c_LN_W  = $clog2(NUM_LINES);
  localparam int c_IDX_W = (c_LN_W > 0) ? c_LN_W : 1;
  localparam int c_TAG_W = ADDR_W - c_OFF_W - c_LN_W;

  localparam logic [ADDR_W-1:0] c_OFF_RDCMD = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] c_OFF_WRCMD = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] c_OFF_WAIT  = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] c_OFF_MODE  = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] c_OFF_CTRL  = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] c_OFF_STAT  = ADDR_W'(8'h14);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FILL = 3'd1, S_RDW = 3'd2, S_WR = 3'd3, S_RESP = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic              r_ap_valid, r_ap_write, r_ap_cfg;
  logic [1:0]        r_ap_size;
  logic [ADDR_W-1:0] r_ap_addr;

  logic [7:0]        r_rd_cmd, r_wr_cmd;
  logic [WS_W-1:0]   r_wait;
  logic [1:0]        r_mode;
  logic              r_buf_en;
  logic [15:0]       r_hit_cnt, r_miss_cnt;

  logic [31:0]        r_buf [NUM_LINES*LINE_WORDS];
  logic [c_TAG_W-1:0] r_tag [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;

  logic [c_IDX_W-1:0] r_fidx;
  logic [c_TAG_W-1:0] r_ftag;
  logic [c_WO_W-1:0]  r_req_woff;
  logic [c_WO_W:0]    r_fill_cnt;
  logic               r_rdw_got;
  logic [31:0]        r_resp_data;

  logic [c_IDX_W-1:0] w_idx;
  logic [c_TAG_W-1:0] w_tag;
  logic [c_WO_W-1:0]  w_woff;
  logic [31:0]        w_hit_word, w_merged, w_wdata_rj, w_cfg_rdata;
  logic [3:0]         w_lanes;
  logic               w_dp_mem, w_line_hit, w_rd_hit, w_go_fill, w_go_rdw, w_go_wr;
  logic               w_cfg_wr, w_stat_wr, w_fill_wr, w_unused;

  generate
    if (c_LN_W > 0) begin : g_idx
      assign w_idx = r_ap_addr[c_OFF_W +: c_IDX_W];
    end else begin : g_idx_single
      assign w_idx = '0;
    end
  endgenerate

  assign w_tag      = r_ap_addr[ADDR_W-1 -: c_TAG_W];
  assign w_woff     = r_ap_addr[2 +: c_WO_W];
  assign w_hit_word = r_buf[{w_idx, w_woff}];
  assign w_line_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_dp_mem   = (r_state == S_IDLE) && r_ap_valid && !r_ap_cfg;
  assign w_rd_hit   = w_dp_mem && !r_ap_write && r_buf_en && w_line_hit;
  assign w_go_fill  = w_dp_mem && !r_ap_write && r_buf_en && !w_line_hit;
  assign w_go_rdw   = w_dp_mem && !r_ap_write && !r_buf_en;
  assign w_go_wr    = w_dp_mem && r_ap_write;
  assign w_cfg_wr   = (r_state == S_IDLE) && r_ap_valid && r_ap_cfg && r_ap_write;
  assign w_stat_wr  = w_cfg_wr && (r_ap_addr == c_OFF_STAT);
  assign w_fill_wr  = (r_state == S_FILL) && mem_rvalid && !r_fill_cnt[c_WO_W];
  assign w_unused   = &{1'b0, HADDR[31:ADDR_W+1], HSIZE[2], HTRANS[0]};

  always_comb begin
    w_lanes    = 4'hF;
    w_wdata_rj = HWDATA >> {r_ap_addr[1:0], 3'b000};
    case (r_ap_size)
      2'd0: begin
        w_lanes    = 4'b0001 << r_ap_addr[1:0];
        w_wdata_rj = w_wdata_rj & 32'h0000_00FF;
      end
      2'd1: begin
        w_lanes    = 4'b0011 << r_ap_addr[1:0];
        w_wdata_rj = w_wdata_rj & 32'h0000_FFFF;
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++)
      w_merged[8*i +: 8] = w_lanes[i] ? HWDATA[8*i +: 8] : w_hit_word[8*i +: 8];
  end

  always_comb begin
    w_cfg_rdata = '0;
    if      (r_ap_addr == c_OFF_RDCMD) w_cfg_rdata = {24'd0, r_rd_cmd};
    else if (r_ap_addr == c_OFF_WRCMD) w_cfg_rdata = {24'd0, r_wr_cmd};
    else if (r_ap_addr == c_OFF_WAIT)  w_cfg_rdata = 32'(r_wait);
    else if (r_ap_addr == c_OFF_MODE)  w_cfg_rdata = {30'd0, r_mode};
    else if (r_ap_addr == c_OFF_CTRL)  w_cfg_rdata = {31'd0, r_buf_en};
    else if (r_ap_addr == c_OFF_STAT)  w_cfg_rdata = {r_miss_cnt, r_hit_cnt};
  end

  always_comb begin
    HRDATA = '0;
    if (r_state == S_RESP)
      HRDATA = mem_rd_wr ? r_resp_data : 32'd0;
    else if ((r_state == S_IDLE) && r_ap_valid && !r_ap_write)
      HRDATA = r_ap_cfg ? w_cfg_rdata : (w_rd_hit ? w_hit_word : 32'd0);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    HREADYOUT = 1'b0;
    case (r_state)
      S_IDLE: begin
        HREADYOUT = !(w_go_fill || w_go_rdw || w_go_wr);
        if (w_go_fill)     w_next = S_FILL;
        else if (w_go_rdw) w_next = S_RDW;
        else if (w_go_wr)  w_next = S_WR;
      end
      S_FILL, S_RDW, S_WR: if (mem_done) w_next = S_RESP;
      S_RESP: begin
        HREADYOUT = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ap_valid <= 1'b0;
      r_ap_write <= 1'b0;
      r_ap_cfg   <= 1'b0;
      r_ap_size  <= '0;
      r_ap_addr  <= '0;
    end else if (HREADY) begin
      r_ap_valid <= HSEL && HTRANS[1];
      r_ap_write <= HWRITE;
      r_ap_cfg   <= HADDR[ADDR_W];
      r_ap_size  <= HSIZE[1:0];
      r_ap_addr  <= HADDR[ADDR_W-1:0];
    end
  end

  // Line data carries no reset: the valid bits alone decide whether it is used.
  always_ff @(posedge HCLK) begin
    if (w_fill_wr)
      r_buf[{r_fidx, r_fill_cnt[c_WO_W-1:0]}] <= mem_rdata;
    else if (w_go_wr && w_line_hit)
      r_buf[{w_idx, w_woff}] <= w_merged;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mem_start   <= 1'b0;
      mem_rd_wr   <= 1'b0;
      mem_addr    <= '0;
      mem_size    <= '0;
      mem_cmd     <= '0;
      mem_wdata   <= '0;
      mem_wait    <= '0;
      mem_qspi    <= 1'b0;
      mem_qpi     <= 1'b0;
      r_rd_cmd    <= 8'hEB;
      r_wr_cmd    <= 8'h38;
      r_wait      <= WS_W'(6);
      r_mode      <= '0;
      r_buf_en    <= 1'b1;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_valid     <= '0;
      for (int i = 0; i < NUM_LINES; i++) r_tag[i] <= '0;
      r_fidx      <= '0;
      r_ftag      <= '0;
      r_req_woff  <= '0;
      r_fill_cnt  <= '0;
      r_rdw_got   <= 1'b0;
      r_resp_data <= '0;
    end else begin
      mem_start <= 1'b0;
      if (w_go_fill || w_go_rdw || w_go_wr) begin
        mem_start  <= 1'b1;
        mem_rd_wr  <= !r_ap_write;
        mem_cmd    <= r_ap_write ? r_wr_cmd : r_rd_cmd;
        mem_wdata  <= w_go_wr ? w_wdata_rj : 32'd0;
        mem_wait   <= r_wait;
        mem_qspi   <= r_mode[0];
        mem_qpi    <= r_mode[1];
        r_fidx     <= w_idx;
        r_ftag     <= w_tag;
        r_req_woff <= w_woff;
        r_fill_cnt <= '0;
        r_rdw_got  <= 1'b0;
        if (w_go_fill) begin
          mem_addr <= {r_ap_addr[ADDR_W-1:c_OFF_W], c_OFF_W'(0)};
          mem_size <= 7'(4 * LINE_WORDS);
        end else if (w_go_rdw) begin
          mem_addr <= {r_ap_addr[ADDR_W-1:2], 2'b00};
          mem_size <= 7'd4;
        end else begin
          mem_addr <= r_ap_addr;
          mem_size <= (r_ap_size == 2'd0) ? 7'd1 : (r_ap_size == 2'd1) ? 7'd2 : 7'd4;
        end
      end

      if (w_fill_wr) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
        if (r_fill_cnt[c_WO_W-1:0] == r_req_woff) r_resp_data <= mem_rdata;
      end
      if ((r_state == S_RDW) && mem_rvalid && !r_rdw_got) begin
        r_rdw_got   <= 1'b1;
        r_resp_data <= mem_rdata;
      end
      // The bus is stalled for the whole fill, so an invalidate can never overlap one.
      if ((r_state == S_FILL) && mem_done) begin
        r_valid[r_fidx] <= 1'b1;
        r_tag[r_fidx]   <= r_ftag;
      end

      if (w_cfg_wr) begin
        if (r_ap_addr == c_OFF_RDCMD) r_rd_cmd <= HWDATA[7:0];
        if (r_ap_addr == c_OFF_WRCMD) r_wr_cmd <= HWDATA[7:0];
        if (r_ap_addr == c_OFF_WAIT)  r_wait   <= HWDATA[WS_W-1:0];
        if (r_ap_addr == c_OFF_MODE)  r_mode   <= HWDATA[1:0];
        if (r_ap_addr == c_OFF_CTRL) begin
          r_buf_en <= HWDATA[0];
          if (HWDATA[1]) r_valid <= '0;
        end
      end

      if (w_stat_wr) begin
        r_hit_cnt  <= '0;
        r_miss_cnt <= '0;
      end else begin
        if (w_rd_hit && (r_hit_cnt != 16'hFFFF))   r_hit_cnt  <= r_hit_cnt + 1'b1;
        if (w_go_fill && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ef_psram_ahbl_rbuf.sv
`default_nettype none
// ============================================================================
// tb_ef_psram_ahbl_rbuf : scoreboard bench with a simple PSRAM engine model
// Revision: 1.0
// ============================================================================
module tb_ef_psram_ahbl_rbuf;
  localparam int ADDR_W = 24;
  localparam int WS_W   = 4;
  localparam logic [31:0] CFG = 32'h0100_0000;

  logic HCLK, HRESETn, HSEL, HREADY, HWRITE, HREADYOUT;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic mem_start, mem_rd_wr, mem_qspi, mem_qpi, mem_rvalid, mem_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [6:0] mem_size;
  logic [7:0] mem_cmd;
  logic [31:0] mem_wdata, mem_rdata;
  logic [WS_W-1:0] mem_wait;

  assign HREADY = HREADYOUT;

  ef_psram_ahbl_rbuf #(.ADDR_W(ADDR_W), .LINE_WORDS(4), .NUM_LINES(4), .WS_W(WS_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .mem_start(mem_start), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_cmd(mem_cmd), .mem_wdata(mem_wdata), .mem_wait(mem_wait),
    .mem_qspi(mem_qspi), .mem_qpi(mem_qpi),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        rd;
    logic [23:0] addr;
    logic [6:0]  size;
    logic [7:0]  cmd;
    logic [31:0] wdata;
    logic [3:0]  wt;
    logic [1:0]  mode;
  } start_t;

  int n_vec = 0;
  int n_err = 0;
  int n_starts = 0;
  start_t sq[$];
  logic [31:0] rq[$];
  logic [31:0] mem [int];
  logic dp_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_start(input logic rd, input logic [23:0] a, input logic [6:0] sz,
                           input logic [7:0] cmd, input logic [31:0] wd,
                           input logic [3:0] wt, input logic [1:0] mode);
    start_t e;
    e.rd = rd; e.addr = a; e.size = sz; e.cmd = cmd; e.wdata = wd; e.wt = wt; e.mode = mode;
    sq.push_back(e);
  endtask

  // Engine-request monitor
  always @(negedge HCLK) begin : mon_start
    start_t e;
    if (HRESETn && mem_start) begin
      n_starts++;
      if (sq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_start: got addr %h, expected no request", mem_addr);
      end else begin
        e = sq.pop_front();
        check("start_rd_wr", 32'(mem_rd_wr), 32'(e.rd));
        check("start_addr", 32'(mem_addr), 32'(e.addr));
        check("start_size", 32'(mem_size), 32'(e.size));
        check("start_cmd", 32'(mem_cmd), 32'(e.cmd));
        check("start_wait", 32'(mem_wait), 32'(e.wt));
        check("start_mode", {30'd0, mem_qpi, mem_qspi}, 32'(e.mode));
        if (!e.rd) check("start_wdata", mem_wdata, e.wdata);
      end
    end
  end

  // Read-data monitor
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dp_rd <= 1'b0;
    else if (HREADY) dp_rd <= HSEL && HTRANS[1] && !HWRITE;
  end

  always @(negedge HCLK) begin
    if (HRESETn && dp_rd && HREADYOUT) begin
      if (rq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_read: got %h, expected no read completion", HRDATA);
      end else begin
        check("hrdata", HRDATA, rq.pop_front());
      end
    end
  end

  // PSRAM engine model
  task automatic engine_run();
    logic [23:0] a;
    logic [6:0]  sz;
    logic        rd;
    logic [31:0] wd, w;
    int          wi;
    bit          abort;
    a = mem_addr; sz = mem_size; rd = mem_rd_wr; wd = mem_wdata; abort = 0;
    for (int i = 0; i < 2 && !abort; i++) begin
      @(negedge HCLK); abort = !HRESETn;
    end
    if (rd) begin
      for (int i = 0; i < int'(sz) / 4 && !abort; i++) begin
        wi = int'(a >> 2) + i;
        mem_rvalid = 1'b1;
        mem_rdata  = mem.exists(wi) ? mem[wi] : 32'd0;
        @(negedge HCLK); abort = !HRESETn;
      end
      mem_rvalid = 1'b0;
    end else begin
      for (int b = 0; b < int'(sz); b++) begin
        wi = int'((a + 24'(b)) >> 2);
        w  = mem.exists(wi) ? mem[wi] : 32'd0;
        w[8*((int'(a) + b) % 4) +: 8] = wd[8*b +: 8];
        mem[wi] = w;
      end
    end
    if (!abort && HRESETn) begin
      mem_done = 1'b1;
      @(negedge HCLK);
      mem_done = 1'b0;
    end
  endtask

  initial begin
    mem_rvalid = 1'b0; mem_rdata = '0; mem_done = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESETn && mem_start) engine_run();
    end
  end

  task automatic bus(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                     input logic [31:0] wd, output int waits);
    int t;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = sz;
    t = 0;
    while (!HREADYOUT && t < 300) begin @(posedge HCLK); #1; t++; end
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
    waits = 0;
    while (!HREADYOUT && waits < 300) begin @(posedge HCLK); #1; waits++; end
    if (waits >= 300) begin
      n_vec++; n_err++;
      $display("FAIL bus_timeout: got no HREADYOUT after %0d cycles at %h, expected completion", waits, a);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input bit zero_wait);
    int w;
    rq.push_back(exp);
    bus(a, 1'b0, 3'd2, 32'd0, w);
    if (zero_wait) check("zero_wait", 32'(w), 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int w;
    bus(a, 1'b1, sz, d, w);
  endtask

  initial begin : stim
    int t, s0, w;
    HSEL = 0; HWRITE = 0; HADDR = 0; HTRANS = 0; HSIZE = 0; HWDATA = 0;
    for (int i = 0; i < 4; i++) begin
      mem[32'h40 + i] = 32'hA0 + i;
      mem[32'h80 + i] = 32'hB0 + i;
    end
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_mem_start", 32'(mem_start), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_mem_cmd", 32'(mem_cmd), 32'd0);
    check("rst_mem_wait", 32'(mem_wait), 32'd0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Register reset values
    rd(CFG + 32'h14, 32'h0000_0000, 1);
    rd(CFG + 32'h00, 32'h0000_00EB, 1);
    rd(CFG + 32'h04, 32'h0000_0038, 1);
    rd(CFG + 32'h08, 32'h0000_0006, 1);
    rd(CFG + 32'h0C, 32'h0000_0000, 1);
    rd(CFG + 32'h10, 32'h0000_0001, 1);
    rd(CFG + 32'h18, 32'h0000_0000, 1);

    // Line fill then hit
    exp_start(1, 24'h000100, 7'd16, 8'hEB, 32'd0, 4'd6, 2'd0);
    rd(32'h0000_0104, 32'h0000_00A1, 0);
    rd(32'h0000_010C, 32'h0000_00A3, 1);
    rd(CFG + 32'h14, 32'h0001_0001, 1);

    // Byte write-through merged into the line
    exp_start(0, 24'h000106, 7'd1, 8'h38, 32'h0000_005A, 4'd6, 2'd0);
    wr(32'h0000_0106, 3'd0, 32'h115A_2233);
    rd(32'h0000_0104, 32'h005A_00A1, 1);
    rd(CFG + 32'h14, 32'h0001_0002, 1);

    // Buffer disabled: uncached word reads, counters frozen
    wr(CFG + 32'h10, 3'd2, 32'h0);
    exp_start(1, 24'h000100, 7'd4, 8'hEB, 32'd0, 4'd6, 2'd0);
    rd(32'h0000_0100, 32'h0000_00A0, 0);
    exp_start(1, 24'h000100, 7'd4, 8'hEB, 32'd0, 4'd6, 2'd0);
    rd(32'h0000_0100, 32'h0000_00A0, 0);
    rd(CFG + 32'h14, 32'h0001_0002, 1);

    // Re-enable, then invalidate forces a fresh fill
    wr(CFG + 32'h10, 3'd2, 32'h1);
    rd(32'h0000_0104, 32'h005A_00A1, 1);
    wr(CFG + 32'h10, 3'd2, 32'h3);
    rd(CFG + 32'h10, 32'h0000_0001, 1);
    exp_start(1, 24'h000100, 7'd16, 8'hEB, 32'd0, 4'd6, 2'd0);
    rd(32'h0000_0100, 32'h0000_00A0, 0);
    rd(CFG + 32'h14, 32'h0002_0003, 1);
    wr(CFG + 32'h14, 3'd2, 32'hFFFF_FFFF);
    rd(CFG + 32'h14, 32'h0000_0000, 1);

    // New wait/mode, conflicting line eviction, halfword merge
    wr(CFG + 32'h08, 3'd2, 32'h9);
    wr(CFG + 32'h0C, 3'd2, 32'h3);
    exp_start(1, 24'h000200, 7'd16, 8'hEB, 32'd0, 4'd9, 2'd3);
    rd(32'h0000_0208, 32'h0000_00B2, 0);
    exp_start(1, 24'h000100, 7'd16, 8'hEB, 32'd0, 4'd9, 2'd3);
    rd(32'h0000_0104, 32'h005A_00A1, 0);
    exp_start(0, 24'h00010A, 7'd2, 8'h38, 32'h0000_BEEF, 4'd9, 2'd3);
    wr(32'h0000_010A, 3'd1, 32'hBEEF_0000);
    rd(32'h0000_0108, 32'hBEEF_00A2, 1);
    rd(CFG + 32'h14, 32'h0002_0001, 1);

    // Reset in the middle of a fill
    exp_start(1, 24'h000300, 7'd16, 8'hEB, 32'd0, 4'd9, 2'd3);
    s0 = n_starts;
    fork
      bus(32'h0000_0300, 1'b0, 3'd2, 32'd0, w);
      begin
        t = 0;
        while (n_starts == s0 && t < 100) begin @(posedge HCLK); #1; t++; end
        if (t >= 100) begin
          n_vec++; n_err++;
          $display("FAIL fill_start_timeout: got no mem_start, expected one");
        end
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        #1;
        check("midfill_rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("midfill_rst_mem_start", 32'(mem_start), 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
      end
    join
    repeat (6) @(posedge HCLK);
    #1;
    rd(CFG + 32'h08, 32'h0000_0006, 1);
    exp_start(1, 24'h000100, 7'd16, 8'hEB, 32'd0, 4'd6, 2'd0);
    rd(32'h0000_0104, 32'h005A_00A1, 0);
    rd(CFG + 32'h14, 32'h0001_0000, 1);

    repeat (4) @(posedge HCLK);
    #1;
    check("starts_outstanding", 32'(sq.size()), 32'd0);
    check("reads_outstanding", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected $finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
